// File: rtl/lma_pkg.sv
// lma_pkg: shared constants and types for the layer memory arbiter.
// Holds layer-select codes, address/data widths, FSM state enum and the
// legal-select helper used by layer_mem_arb.
package lma_pkg;

  localparam int AW = 12;
  localparam int DW = 20;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Only the two defined layers may reach the memory.
  function automatic logic sel_legal(input logic [2:0] s);
    return (s == CSEL_L0) || (s == CSEL_L1);
  endfunction

endpackage

// File: rtl/lma_grant_sel.sv
// lma_grant_sel: picks the winning requester for the next arbitration.
// Ports: req0/req1 requests in, pick1 (1 = requester 1 wins) out; with
// ARB_STARVE_GUARD_EN defined also clk/reset and arb (arbitration edge strobe).
// ARB_STARVE_GUARD_EN: defined -> R0 bursts capped at BURST_MAX while R1 waits;
// undefined -> strict R0 priority, purely combinational.
module lma_grant_sel
  import lma_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int BURST_MAX = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic reset,
  input  logic arb,
`endif
  input  logic req0,
  input  logic req1,
  output logic pick1
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);

  // Consecutive R0 grants taken while R1 was waiting.
  logic [CW-1:0] cnt;
  logic          due;

  assign due   = (cnt >= CW'(BURST_MAX));
  assign pick1 = req1 & (~req0 | due);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (arb && (req0 || req1)) begin
      // An R1 grant, or an R0 grant nobody else wanted, ends the burst.
      if (pick1 || !req1) cnt <= '0;
      else                cnt <= cnt + 1'b1;
    end
  end
`else
  assign pick1 = req1 & ~req0;
`endif

endmodule

// File: rtl/layer_mem_arb.sv
// layer_mem_arb: two-requester arbiter in front of a layer-selected memory.
// Ports: clk, reset (sync, active-low); per requester reqk/wek/selk/addrk/wdatak
// in, gntk/rvalidk/rdatak out; memory side cwr/caddr_wr/cdata_wr/crd/caddr_rd/
// csel out, cdata_rd in; status arb_busy, err (sticky illegal select).
// One access per two cycles (IDLE -> ISSUE); reads return two cycles after the
// sampling edge. Macro ARB_STARVE_GUARD_EN enables the R0 burst limit.
module layer_mem_arb
  import lma_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [2:0]    sel0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [2:0]    sel1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [2:0]    csel,
  output logic          arb_busy,
  output logic          err
);

  state_t        state;
  logic          pick1;
  logic          w_we;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          rd_pend;   // current ISSUE is a read (legal or not)
  logic          rd_owner;  // 1 = read belongs to requester 1

  lma_grant_sel
`ifdef ARB_STARVE_GUARD_EN
    #(.BURST_MAX(BURST_MAX))
`endif
    u_grant_sel (
`ifdef ARB_STARVE_GUARD_EN
      .clk   (clk),
      .reset (reset),
      .arb   (state == ST_IDLE),
`endif
      .req0  (req0),
      .req1  (req1),
      .pick1 (pick1)
    );

  always_comb begin
    w_we    = pick1 ? we1    : we0;
    w_sel   = pick1 ? sel1   : sel0;
    w_addr  = pick1 ? addr1  : addr0;
    w_wdata = pick1 ? wdata1 : wdata0;
  end

  assign arb_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= CSEL_NONE;
      err      <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      // Memory strobes and pulses default low; data outputs hold.
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= CSEL_NONE;
      rd_pend  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state    <= ST_ISSUE;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            rd_pend  <= ~w_we;
            rd_owner <= pick1;
            if (sel_legal(w_sel)) begin
              csel <= w_sel;
              if (w_we) begin
                cwr      <= 1'b1;
                caddr_wr <= w_addr;
                cdata_wr <= w_wdata;
              end else begin
                crd      <= 1'b1;
                caddr_rd <= w_addr;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_IDLE;
          // crd is high only for a legal read, so illegal reads return zero.
          if (rd_pend) begin
            if (rd_owner) begin
              rvalid1 <= 1'b1;
              rdata1  <= crd ? cdata_rd : '0;
            end else begin
              rvalid0 <= 1'b1;
              rdata0  <= crd ? cdata_rd : '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mem_arb.sv
module tb_layer_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [2:0]  sel0, sel1;
  logic [11:0] addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1;
  logic [19:0] rdata0, rdata1;
  logic        cwr, crd;
  logic [11:0] caddr_wr, caddr_rd;
  logic [19:0] cdata_wr, cdata_rd;
  logic [2:0]  csel;
  logic        arb_busy, err;

  logic [19:0] rd_word;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Memory returns the staged word only while a read strobe is present.
  assign cdata_rd = crd ? rd_word : 20'h0;

  layer_mem_arb #(.BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .sel0(sel0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .sel1(sel1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .arb_busy(arb_busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; we0 = 0; sel0 = 3'b000; addr0 = 12'h0; wdata0 = 20'h0;
    req1 = 0; we1 = 0; sel1 = 3'b000; addr1 = 12'h0; wdata1 = 20'h0;
    rd_word = 20'h0;
    tick(); tick(); tick();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_cwr", cwr, 0);
    chk("rst_crd", crd, 0);
    chk("rst_csel", csel, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata1", rdata1, 0);
    reset = 1'b1;
    tick();

    // R0 write alone
    req0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h041; wdata0 = 20'h12345;
    tick();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_gnt1", gnt1, 0);
    chk("wr_cwr", cwr, 1);
    chk("wr_caddr", caddr_wr, 12'h041);
    chk("wr_cdata", cdata_wr, 20'h12345);
    chk("wr_csel", csel, 3'b001);
    chk("wr_crd", crd, 0);
    chk("wr_caddr_rd", caddr_rd, 0);
    chk("wr_busy", arb_busy, 1);
    req0 = 0;
    tick();
    chk("wr_gnt0_end", gnt0, 0);
    chk("wr_cwr_end", cwr, 0);
    chk("wr_caddr_end", caddr_wr, 0);
    chk("wr_csel_end", csel, 0);
    chk("wr_busy_end", arb_busy, 0);

    // R1 read
    req1 = 1; we1 = 0; sel1 = 3'b001; addr1 = 12'h080; rd_word = 20'h0ABCD;
    tick();
    chk("rd_gnt1", gnt1, 1);
    chk("rd_gnt0", gnt0, 0);
    chk("rd_crd", crd, 1);
    chk("rd_caddr", caddr_rd, 12'h080);
    chk("rd_csel", csel, 3'b001);
    chk("rd_cwr", cwr, 0);
    chk("rd_cdata_wr", cdata_wr, 0);
    req1 = 0;
    tick();
    chk("rd_rvalid1", rvalid1, 1);
    chk("rd_rdata1", rdata1, 20'h0ABCD);
    chk("rd_rvalid0", rvalid0, 0);
    chk("rd_crd_end", crd, 0);
    tick();
    chk("rd_rvalid1_drop", rvalid1, 0);
    chk("rd_rdata1_hold", rdata1, 20'h0ABCD);

    // Illegal select on a write
    req0 = 1; we0 = 1; sel0 = 3'b010; addr0 = 12'h123; wdata0 = 20'h0F0F0;
    tick();
    chk("ill_gnt0", gnt0, 1);
    chk("ill_cwr", cwr, 0);
    chk("ill_crd", crd, 0);
    chk("ill_err", err, 1);
    req0 = 0;
    tick();
    chk("ill_err_sticky", err, 1);

    // Legal R0 read after the error
    req0 = 1; we0 = 0; sel0 = 3'b011; addr0 = 12'h200; rd_word = 20'h54321;
    tick();
    chk("post_gnt0", gnt0, 1);
    chk("post_crd", crd, 1);
    chk("post_csel", csel, 3'b011);
    chk("post_err", err, 1);
    req0 = 0;
    tick();
    chk("post_rvalid0", rvalid0, 1);
    chk("post_rdata0", rdata0, 20'h54321);

    // Illegal select on a read returns zero data
    req1 = 1; we1 = 0; sel1 = 3'b111; addr1 = 12'h300; rd_word = 20'hFFFFF;
    tick();
    chk("illrd_gnt1", gnt1, 1);
    chk("illrd_crd", crd, 0);
    req1 = 0;
    tick();
    chk("illrd_rvalid1", rvalid1, 1);
    chk("illrd_rdata1", rdata1, 0);

    // Requester 1 withdraws before being granted
    req0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h010; wdata0 = 20'h00001;
    req1 = 1; we1 = 0; sel1 = 3'b001; addr1 = 12'h020;
    tick();
    chk("stale_gnt0", gnt0, 1);
    chk("stale_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    tick();
    tick();
    chk("stale_no_gnt1", gnt1, 0);
    chk("stale_idle", arb_busy, 0);

    // Reset during a read ISSUE
    req1 = 1; we1 = 0; sel1 = 3'b001; addr1 = 12'h0F0; rd_word = 20'h11111;
    tick();
    chk("rstrd_crd", crd, 1);
    reset = 1'b0; req1 = 0;
    tick();
    chk("rstrd_crd0", crd, 0);
    chk("rstrd_caddr0", caddr_rd, 0);
    chk("rstrd_csel0", csel, 0);
    chk("rstrd_gnt1", gnt1, 0);
    chk("rstrd_busy", arb_busy, 0);
    chk("rstrd_rvalid1", rvalid1, 0);
    chk("rstrd_rdata1", rdata1, 0);
    chk("rstrd_err", err, 0);
    reset = 1'b1;
    tick();
    chk("rstrd_no_rvalid", rvalid1, 0);
    req0 = 1; we0 = 1; sel0 = 3'b011; addr0 = 12'h7FF; wdata0 = 20'hFFFFF;
    tick();
    chk("after_gnt0", gnt0, 1);
    chk("after_cwr", cwr, 1);
    chk("after_caddr", caddr_wr, 12'h7FF);
    chk("after_cdata", cdata_wr, 20'hFFFFF);
    chk("after_csel", csel, 3'b011);
    req0 = 0;
    tick();

    // Both requesters held high continuously
    req0 = 1; we0 = 1; sel0 = 3'b001; addr0 = 12'h001; wdata0 = 20'h00001;
    req1 = 1; we1 = 0; sel1 = 3'b001; addr1 = 12'h002; rd_word = 20'h00002;
    for (int i = 0; i < 10; i++) begin
      logic exp1;
`ifdef ARB_STARVE_GUARD_EN
      exp1 = ((i % 5) == 4);
`else
      exp1 = 1'b0;
`endif
      tick();
      chk($sformatf("burst%0d_gnt0", i), gnt0, {31'd0, ~exp1});
      chk($sformatf("burst%0d_gnt1", i), gnt1, {31'd0, exp1});
      tick();
    end
    req0 = 0; req1 = 0;
    tick();
    tick();
    chk("final_idle", arb_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_mem_arb.md
LAYER_MEM_ARB -- requirements
Module: layer_mem_arb

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, meaning max consecutive R0 grants while R1 is pending (guard build only).
REQ-002 SHALL have ports clk input 1 (clock) and reset input 1 (synchronous, active-low reset), listed first.
REQ-003 SHALL have per requester k∈{0,1}: reqk input 1 (request); wek input 1 (1=write, 0=read); selk input 3 (layer select); addrk input 12 (address); wdatak input 20 (write data).
REQ-004 SHALL have per requester k∈{0,1}: gntk output 1 (issue pulse); rvalidk output 1 (read data valid); rdatak output 20 (read data).
REQ-005 SHALL have memory-side ports cwr output 1, caddr_wr output 12, cdata_wr output 20, crd output 1, caddr_rd output 12, cdata_rd input 20, csel output 3.
REQ-006 SHALL have status ports arb_busy output 1 (state≠IDLE) and err output 1 (sticky illegal-select flag).

Function
REQ-007 SHALL implement a two-state FSM: IDLE→ISSUE when req0|req1 is sampled high; ISSUE→IDLE unconditionally. Maximum throughput: one access per 2 cycles.
REQ-008 SHALL latch the winner's we, sel, addr and wdata on the IDLE→ISSUE edge; all memory outputs SHALL be registered.
REQ-009 SHALL assert gntk for exactly the ISSUE cycle of the winner; the requester SHALL hold its command stable until it sees gnt, and may update it on the following cycle.
REQ-010 SHALL, during an ISSUE write, drive cwr=1, caddr_wr=addr, cdata_wr=wdata and csel=sel, with crd=0 and caddr_rd=0.
REQ-011 SHALL, during an ISSUE read, drive crd=1, caddr_rd=addr and csel=sel, with cwr=0, caddr_wr=0 and cdata_wr=0.
REQ-012 SHALL, outside ISSUE, drive cwr=crd=0, all addresses/data=0 and csel=000.
REQ-013 SHALL capture cdata_rd at the end of a read ISSUE cycle, then pulse rvalidk with rdatak=captured value in the next cycle (read latency 2 cycles from the sampling edge). rdatak SHALL hold its value otherwise.
REQ-014 SHALL give R0 fixed priority on a simultaneous request (baseline).
REQ-015 SHALL treat only sel values 001 and 011 as legal. On any other value: gnt is still issued, cwr/crd are suppressed, read returns rvalid with rdata=0, and err is set and held until reset.
REQ-016 SHALL, when a requester drops req before being granted, not grant it (no stale grant).

Reset
REQ-017 SHALL, with reset=0 at a clock edge, set state=IDLE, all outputs=0, err=0 and the burst counter=0.
REQ-018 SHALL, on reset asserted during ISSUE, abort the access; no rvalid SHALL follow.

Configuration
REQ-019 SHALL honour macro ARB_STARVE_GUARD_EN as follows.
- Defined: a counter of consecutive R0 grants made while req1 was high. When it reaches BURST_MAX, the next arbitration grants R1 and the counter clears.
- Defined: the counter clears on any R1 grant, and on an R0 grant while req1 is low.
- Undefined: strict R0 priority with no counter logic; BURST_MAX is unused.

Structure
REQ-020 SHALL place in shared package lma_pkg: the csel codes (CSEL_NONE=000, CSEL_L0=001, CSEL_L1=011), the address/data widths (12/20), and the FSM state enum.
REQ-021 SHALL implement the winner selection and starvation counter in one sub-module, lma_grant_sel.

Verification
REQ-022 SHALL cover: R0 write alone (sel=001, addr=0x041, wdata=0x12345) → next cycle cwr=1, caddr_wr=0x041, cdata_wr=0x12345, csel=001, gnt0=1 for 1 cycle.
REQ-023 SHALL cover: R1 read (sel=001, addr=0x080), bench memory returns 0x0ABCD → crd=1, caddr_rd=0x080 in ISSUE; rvalid1=1, rdata1=0x0ABCD one cycle later.
REQ-024 SHALL cover: req0 and req1 held high continuously, guard build with BURST_MAX=4 → grant order 0,0,0,0,1,0,0,0,0,1. Non-guard build → R1 never granted.
REQ-025 SHALL cover: R0 request with sel=010 → gnt0=1, cwr=0, err=1 and stays 1; a following legal access proceeds normally.
REQ-026 SHALL cover: reset=0 asserted during a read ISSUE → all outputs 0 next cycle, no rvalid1; first request after release is served normally.
